// File: rtl/core_run_controller_if.sv
// Host-side signal bundle of the run controller: start/config, load stream,
// DRAM port, core enable/end flags, result stream and status.
interface core_run_controller_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned CYC_W     = 32
);
    logic                 start;
    logic [ADDR_W-1:0]    load_len;
    logic [2:0]           no_cores;

    logic [DATA_W-1:0]    in_data;
    logic                 in_valid;
    logic                 in_ready;

    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_rdata;

    logic [NUM_CORES-1:0] enable;
    logic [NUM_CORES-1:0] core_done;

    logic [DATA_W-1:0]    out_data;
    logic                 out_valid;
    logic                 out_ready;

    logic [CYC_W-1:0]     cycle_count;
    logic                 busy;
    logic                 done;
    logic                 timeout;

    modport master (
        input  start, load_len, no_cores, in_data, in_valid, mem_rdata,
               core_done, out_ready,
        output in_ready, mem_addr, mem_wdata, mem_we, enable, out_data,
               out_valid, cycle_count, busy, done, timeout
    );

    modport slave (
        output start, load_len, no_cores, in_data, in_valid, mem_rdata,
               core_done, out_ready,
        input  in_ready, mem_addr, mem_wdata, mem_we, enable, out_data,
               out_valid, cycle_count, busy, done, timeout
    );
endinterface

// File: rtl/core_run_controller.sv
// Load/run/read-back sequencer: streams an image into DRAM, runs the selected
// cores until all report done (or the run times out), then streams results out.
module core_run_controller #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned OUT_BASE   = 32,
    parameter int unsigned OUT_LEN    = 16,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned MAX_CYCLES = 2**20
) (
    input  logic                  clk,
    input  logic                  rst,
    core_run_controller_if.master bus
);
    localparam int unsigned IDX_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, RD_ADDR, RD_WAIT, RD_OUT, FIN} state_t;
    state_t state, state_next;

    logic [ADDR_W-1:0]    len_q;
    logic [ADDR_W-1:0]    ptr;
    logic [NUM_CORES-1:0] mask;
    logic [NUM_CORES-1:0] mask_new;
    logic [IDX_W-1:0]     idx;
    logic                 first_run;
    logic [CYC_W-1:0]     cycle_count;
    logic [DATA_W-1:0]    out_data;
    logic                 done;
    logic                 timeout;

    logic                 accept;
    logic                 beat;
    logic                 complete;
    logic                 at_limit;
    logic                 timeout_hit;
    logic                 out_hs;
    logic                 last_word;
    logic                 in_ready;
    logic                 mem_we;
    logic                 out_valid;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [NUM_CORES-1:0] enable;
    int unsigned          n_req;

    // Requested core count: 0 means one core, anything above NUM_CORES clamps.
    always_comb begin
        n_req = {29'd0, bus.no_cores};
        if (n_req == 0)
            n_req = 1;
        else if (n_req > NUM_CORES)
            n_req = NUM_CORES;
        mask_new = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++)
            mask_new[i] = (i < n_req);
    end

    assign at_limit  = (cycle_count == CYC_W'(MAX_CYCLES));
    assign last_word = (idx == IDX_W'(OUT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        beat        = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        out_hs      = 1'b0;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        enable      = '0;
        out_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = (bus.load_len == '0) ? RUN : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                mem_addr = ptr;
                if (bus.in_valid) begin
                    beat      = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = bus.in_data;
                    if (ptr == len_q - ADDR_W'(1))
                        state_next = RUN;
                end
            end
            RUN: begin
                enable = mask;
                // End flags may still be high from the previous run on entry.
                complete = !first_run && (&(bus.core_done | ~mask));
                if (complete) begin
                    state_next = RD_ADDR;
                end else if (at_limit) begin
                    timeout_hit = 1'b1;
                    state_next  = RD_ADDR;
                end
            end
            RD_ADDR: begin
                mem_addr   = ADDR_W'(OUT_BASE) + ADDR_W'(idx);
                state_next = RD_WAIT;
            end
            RD_WAIT: state_next = RD_OUT;
            RD_OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    out_hs     = 1'b1;
                    state_next = last_word ? FIN : RD_ADDR;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            ptr         <= '0;
            mask        <= '0;
            idx         <= '0;
            first_run   <= 1'b1;
            cycle_count <= '0;
            out_data    <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            first_run <= (state != RUN);
            if (accept) begin
                len_q       <= bus.load_len;
                mask        <= mask_new;
                ptr         <= '0;
                idx         <= '0;
                cycle_count <= '0;
                done        <= 1'b0;
                timeout     <= 1'b0;
            end
            if (beat)
                ptr <= ptr + ADDR_W'(1);
            if (state == RUN && !complete && !at_limit)
                cycle_count <= cycle_count + CYC_W'(1);
            if (timeout_hit)
                timeout <= 1'b1;
            if (state == RD_WAIT)
                out_data <= bus.mem_rdata;
            if (out_hs) begin
                idx <= idx + IDX_W'(1);
                if (last_word)
                    done <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.enable      = enable;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.cycle_count = cycle_count;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done;
    assign bus.timeout     = timeout;
endmodule

// File: tb/tb_core_run_controller.sv
// Directed + randomized bench for core_run_controller with a behavioural DRAM
// and an expected-memory model built from the load stream.
module tb_core_run_controller;
    localparam int unsigned NC   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 12;
    localparam int unsigned OB   = 32;
    localparam int unsigned OL   = 16;
    localparam int unsigned CW   = 32;
    localparam int unsigned MAXC = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_run_controller_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .CYC_W(CW)) bus ();

    core_run_controller #(
        .NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .OUT_BASE(OB),
        .OUT_LEN(OL), .CYC_W(CW), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] dram    [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    int errors = 0;
    int checks = 0;

    // DRAM with one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_we)
            dram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= dram[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC-1:0] exp_mask(input int nc);
        int n;
        n = (nc == 0) ? 1 : ((nc > int'(NC)) ? int'(NC) : nc);
        return NC'((1 << n) - 1);
    endfunction

    task automatic check_reset();
        check("rst_enable",    64'(bus.enable),      64'(0));
        check("rst_mem_we",    64'(bus.mem_we),      64'(0));
        check("rst_mem_addr",  64'(bus.mem_addr),    64'(0));
        check("rst_mem_wdata", 64'(bus.mem_wdata),   64'(0));
        check("rst_in_ready",  64'(bus.in_ready),    64'(0));
        check("rst_out_valid", 64'(bus.out_valid),   64'(0));
        check("rst_out_data",  64'(bus.out_data),    64'(0));
        check("rst_cycle_cnt", 64'(bus.cycle_count), 64'(0));
        check("rst_busy",      64'(bus.busy),        64'(0));
        check("rst_done",      64'(bus.done),        64'(0));
        check("rst_timeout",   64'(bus.timeout),     64'(0));
    endtask

    // One full start/load/run/read-back job.
    // dly: RUN cycle index at which the enabled cores raise their end flags.
    task automatic do_job(input int len, input int nc, input int dly, input int gap_pct,
                          input int stall_word, input int rstall_pct, input bit junk,
                          input bit seq);
        logic [NC-1:0] m;
        logic [NC-1:0] cd;
        logic [DW-1:0] d;
        logic          exp_to;
        int            e, k, w, budget, held;
        m      = exp_mask(nc);
        exp_to = (dly > int'(MAXC));
        e      = exp_to ? int'(MAXC) : dly;

        @(negedge clk);
        bus.start    = 1'b1;
        bus.load_len = AW'(len);
        bus.no_cores = 3'(nc);
        #1 check("idle_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.load_len = AW'($urandom);
        bus.no_cores = 3'($urandom);

        k = 0;
        budget = 0;
        while (k < len && budget < 4000) begin
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            d = seq ? DW'(k + 1) : DW'($urandom);
            bus.in_data = d;
            #1;
            check("in_ready", 64'(bus.in_ready), 64'(1));
            check("load_we",  64'(bus.mem_we),   64'(bus.in_valid));
            if (bus.in_valid) begin
                check("load_addr", 64'(bus.mem_addr),  64'(k));
                check("load_data", 64'(bus.mem_wdata), 64'(d));
                exp_mem[k] = d;
                k++;
            end
            budget++;
            @(negedge clk);
        end
        if (k < len)
            check("load_budget", 64'(k), 64'(len));
        bus.in_valid = 1'b0;

        for (int c = 0; c <= e; c++) begin
            cd = (c >= dly) ? m : '0;
            if (junk)
                cd = cd | (~m & NC'($urandom));
            if (junk && c == 0)
                cd = '1;
            bus.core_done = cd;
            bus.start     = junk && ($urandom_range(3) == 0);
            bus.load_len  = AW'($urandom);
            #1;
            check("run_enable", 64'(bus.enable), 64'(m));
            if (c == 0) begin
                check("run_in_ready", 64'(bus.in_ready),    64'(0));
                check("run_cnt_clr",  64'(bus.cycle_count), 64'(0));
                check("run_done_clr", 64'(bus.done),        64'(0));
                check("run_to_clr",   64'(bus.timeout),     64'(0));
            end
            @(negedge clk);
        end
        bus.start     = 1'b0;
        bus.core_done = junk ? NC'($urandom) : '0;
        #1;
        check("enable_off",  64'(bus.enable),      64'(0));
        check("cycle_count", 64'(bus.cycle_count), 64'(e));
        check("timeout",     64'(bus.timeout),     64'(exp_to));
        check("rd_busy",     64'(bus.busy),        64'(1));

        w = 0;
        budget = 0;
        held = 0;
        while (w < int'(OL) && budget < 400) begin
            bus.out_ready = !(w == stall_word && held < 3) && ($urandom_range(99) >= rstall_pct);
            #1;
            check("rd_mem_we", 64'(bus.mem_we), 64'(0));
            if (bus.out_valid) begin
                check("out_data", 64'(bus.out_data), 64'(exp_mem[int'(OB) + w]));
                if (bus.out_ready)
                    w++;
                else if (w == stall_word)
                    held++;
            end
            budget++;
            @(negedge clk);
        end
        if (w < int'(OL))
            check("rd_budget", 64'(w), 64'(OL));
        bus.out_ready = 1'b0;
        #1;
        check("fin_done", 64'(bus.done), 64'(1));
        check("fin_busy", 64'(bus.busy), 64'(1));
        @(negedge clk);
        #1;
        check("end_busy",    64'(bus.busy),        64'(0));
        check("end_done",    64'(bus.done),        64'(1));
        check("end_timeout", 64'(bus.timeout),     64'(exp_to));
        check("end_count",   64'(bus.cycle_count), 64'(e));
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.load_len  = '0;
        bus.no_cores  = '0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.core_done = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset();
        rst = 1'b0;

        // fill the result window and below it with random data
        do_job(48, 3, 9, 20, 5, 20, 1'b1, 1'b0);
        do_job(8, 4, 20, 0, -1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            check("dram_seq", 64'(dram[i]), 64'(i + 1));
        do_job(6, 2, 5, 0, -1, 0, 1'b0, 1'b0);
        do_job(4, 0, 3, 0, -1, 0, 1'b1, 1'b0);
        do_job(0, 7, 4, 0, -1, 0, 1'b1, 1'b0);
        do_job(20, 3, 7, 40, 2, 0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            check("dram_load", 64'(dram[i]), 64'(exp_mem[i]));
        do_job(5, 4, 1000, 10, -1, 10, 1'b1, 1'b0);

        // reset in the middle of a run
        @(negedge clk);
        bus.core_done = '0;
        bus.start     = 1'b1;
        bus.load_len  = '0;
        bus.no_cores  = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("pre_rst_enable", 64'(bus.enable), 64'(4'hf));
        rst = 1'b1;
        @(negedge clk);
        #1 check_reset();
        rst = 1'b0;
        do_job(10, 4, 12, 0, -1, 0, 1'b0, 1'b1);

        for (int j = 0; j < 6; j++)
            do_job(int'($urandom_range(40)), int'($urandom_range(7)), int'($urandom_range(30, 1)),
                   int'($urandom_range(50)), int'($urandom_range(OL - 1)),
                   int'($urandom_range(40)), 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
